sram_controller: RTL and testbench
==================================

# sram_controller

Responder side of the MEM-stage data-memory interface. Accepts 32-bit word read/write requests from the pipeline's memory stage and serves them from an external 16-bit asynchronous SRAM as two half-word accesses. While a request is in progress it holds `ready` low so the pipeline freezes. It sits between the EXE/MEM pipeline register and the off-chip SRAM pins, replacing the single-cycle data memory.

## Interface
- `SRAM_ADDR_W`, 18: external SRAM half-word address width.
- `WAIT_CYCLES`, 2: cycles each half-word access is held on the pins; legal range 1–15.
- `DATA_BASE`, 1024: byte address mapped to SRAM word 0.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rd_en` in 1: word read request; level, held by the pipeline until `ready`.
- `wr_en` in 1: word write request; level, held until `ready`.
- `address` in 32: byte address; held stable while a request is pending.
- `write_data` in 32: store value; held stable while a request is pending.
- `read_data` out 32: assembled read word.
- `ready` out 1: low freezes the pipeline; high means no request pending or the request is complete.
- `sram_addr` out SRAM_ADDR_W: half-word address.
- `sram_dq_out` out 16: write data to the pins.
- `sram_dq_in` in 16: read data from the pins (asynchronous SRAM).
- `sram_dq_oe` out 1: drive enable for `sram_dq_out`.
- `sram_we_n` out 1: active-low SRAM write strobe.

## Operation
- Word index = (`address` − DATA_BASE) >> 2, computed modulo 2^32.
- `sram_addr` = {word_index[SRAM_ADDR_W-2:0], half}. Half 0 is the low 16 bits; half 1 is the high 16 bits.
- FSM states: IDLE → LOW → HIGH → DONE → IDLE.
  - IDLE: if `rd_en|wr_en`, latch the op, go to LOW, and drive `ready`=0 combinationally in this same cycle. With no request, `ready`=1.
  - LOW: the wait counter counts WAIT_CYCLES cycles. Drive half-0 address.
    - Write: `sram_dq_oe`=1, `sram_we_n`=0, `sram_dq_out`=`write_data`[15:0].
    - Read: on the final cycle, capture `sram_dq_in` into `read_data`[15:0].
  - HIGH: same as LOW for half 1, using `write_data`[31:16] / `read_data`[31:16].
  - DONE: `ready`=1 for exactly one cycle, pins idle, return to IDLE.
- Simultaneous `rd_en` and `wr_en`: treated as a write; `read_data` is unchanged.
- A request dropped mid-transaction still completes. The op is latched at IDLE exit, so no SRAM cycle is left half-written.
- Idle pin state: `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0.
- `read_data` holds its last value until the next read overwrites it.

## Timing
- Request first seen in IDLE at cycle 0. LOW occupies cycles 1..W and HIGH occupies W+1..2W (W = WAIT_CYCLES). `ready`=1 in cycle 2W+1 (DONE). The pipeline advances at the end of that cycle.
  - W=2: 6 cycles total, 5 freeze cycles.
- `read_data` is valid from the start of DONE.
- `sram_we_n` and address/data change only on clock edges. Address and data are stable across all W cycles of a half, with `we_n` low throughout.
- A new request present in the cycle after DONE starts a new transaction from IDLE. There is no back-to-back bypass.
- Reset (`rst`=0), at any time, asynchronously:
  - state=IDLE, counter=0, `read_data`=0;
  - pins return to the idle state;
  - `ready` then follows `rd_en|wr_en` as in IDLE.
- Reset mid-write may leave the SRAM half-updated; this is accepted.

## Structure
- Shared package `sram_pkg`:
  - state enum (IDLE, LOW, HIGH, DONE);
  - DATA_BASE constant;
  - half-select constants.
- One sub-module, `sram_wait_counter`: 4-bit down-counter with load and a `last` flag, reused for both halves.
- Top FSM, address translation and data assembly live in `sram_controller`.

## Test plan
- Write 0xDEADBEEF to 1024, W=2 → `sram_addr` 0 gets 0xBEEF and `sram_addr` 1 gets 0xDEAD, `we_n` low 2 cycles each; `ready` low cycles 0–4, high cycle 5.
- Read back 1024 after the write → `read_data`=0xDEADBEEF in DONE; `sram_dq_oe` stays 0 throughout.
- Write 0x12345678 to 1032, then read 1028 (previously written 0xCAFEF00D) → `sram_addr` 4/5 written; read returns 0xCAFEF00D.
- `rd_en` and `wr_en` both high at 1024 with data 0x0000FFFF → write performed; `read_data` keeps its previous value.
- `rst` low during cycle 2 of a write (LOW state), then released → immediate `we_n`=1, `oe`=0, `read_data`=0; next request starts fresh with full 2W+2 latency.
- W=1, back-to-back reads at 1024 and 1028 → each read `ready` after 4 cycles, one IDLE cycle between them, correct data both times.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM state encoding and address-map constants for the SRAM controller.
package sram_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;
  localparam logic [31:0] DATA_BASE = 32'd1024;
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable 4-bit down-counter; last_o marks the final cycle of a half-word access.
module sram_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       last_o
);
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
  assign last_o = cnt_q == 4'd1;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: serves 32-bit MEM-stage word requests as two half-word accesses
// on a 16-bit asynchronous SRAM, holding ready low until the word is complete.
module sram_controller #(
  parameter int          SRAM_ADDR_W = 18,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] DATA_BASE   = sram_pkg::DATA_BASE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);
  import sram_pkg::*;
  state_e                 state_q;
  logic                   wr_q, oe_q, we_n_q, last, load;
  logic [31:0]            off, rdata_q;
  logic [15:0]            dq_q;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_lo, addr_hi;
  logic                   unused_bits;
  assign off         = address - DATA_BASE;
  assign unused_bits = ^{off[31:SRAM_ADDR_W+1], off[1:0]};
  assign addr_lo     = {off[SRAM_ADDR_W:2], HALF_LO};
  assign addr_hi     = {off[SRAM_ADDR_W:2], HALF_HI};
  assign load        = (state_q == IDLE && (rd_en | wr_en)) || (state_q == LOW && last);
  sram_wait_counter u_wait (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (4'(WAIT_CYCLES)),
    .last_o     (last)
  );
  // Pins are registered so address, data and we_n only move on clock edges.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dq_q    <= 16'd0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (rd_en | wr_en) begin
          state_q <= LOW;
          wr_q    <= wr_en;
          addr_q  <= addr_lo;
          dq_q    <= wr_en ? write_data[15:0] : 16'd0;
          oe_q    <= wr_en;
          we_n_q  <= !wr_en;
        end
        LOW: if (last) begin
          state_q <= HIGH;
          addr_q  <= addr_hi;
          dq_q    <= wr_q ? write_data[31:16] : 16'd0;
          if (!wr_q) rdata_q[15:0] <= sram_dq_in;
        end
        HIGH: if (last) begin
          state_q <= DONE;
          addr_q  <= '0;
          dq_q    <= 16'd0;
          oe_q    <= 1'b0;
          we_n_q  <= 1'b1;
          if (!wr_q) rdata_q[31:16] <= sram_dq_in;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign ready       = (state_q == IDLE) ? !(rd_en | wr_en) : (state_q == DONE);
  assign read_data   = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed checks of two controllers (W=2 and W=1) against small SRAM models.
module tb_sram_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en [2];
  logic        wr_en [2];
  logic [31:0] address [2];
  logic [31:0] write_data [2];
  logic [31:0] read_data [2];
  logic        ready [2];
  logic [17:0] sram_addr [2];
  logic [15:0] sram_dq_out [2];
  logic [15:0] sram_dq_in [2];
  logic        sram_dq_oe [2];
  logic        sram_we_n [2];
  logic [15:0] mem [2][256];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] rd_tmp;

  always #5 clk = ~clk;

  sram_controller #(.SRAM_ADDR_W(18), .WAIT_CYCLES(2), .DATA_BASE(32'd1024)) u0 (
    .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]), .address(address[0]),
    .write_data(write_data[0]), .read_data(read_data[0]), .ready(ready[0]),
    .sram_addr(sram_addr[0]), .sram_dq_out(sram_dq_out[0]), .sram_dq_in(sram_dq_in[0]),
    .sram_dq_oe(sram_dq_oe[0]), .sram_we_n(sram_we_n[0]));
  sram_controller #(.SRAM_ADDR_W(18), .WAIT_CYCLES(1), .DATA_BASE(32'd1024)) u1 (
    .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]), .address(address[1]),
    .write_data(write_data[1]), .read_data(read_data[1]), .ready(ready[1]),
    .sram_addr(sram_addr[1]), .sram_dq_out(sram_dq_out[1]), .sram_dq_in(sram_dq_in[1]),
    .sram_dq_oe(sram_dq_oe[1]), .sram_we_n(sram_we_n[1]));

  assign sram_dq_in[0] = mem[0][sram_addr[0][7:0]];
  assign sram_dq_in[1] = mem[1][sram_addr[1][7:0]];
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (!sram_we_n[k]) mem[k][sram_addr[k][7:0]] <= sram_dq_out[k];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one request from its IDLE cycle up to its DONE cycle; the request stays asserted on return.
  task automatic do_req(input int k, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] base, output logic [31:0] rd);
    int wc, lat, we_cnt, oe_cnt;
    wc = (k == 0) ? 2 : 1;
    lat = 0; we_cnt = 0; oe_cnt = 0;
    @(negedge clk);
    rd_en[k] = r; wr_en[k] = w; address[k] = a; write_data[k] = d;
    #1 chk("ready_cycle0", 32'(ready[k]), 32'd0);
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (ready[k]) break;
      if (!sram_we_n[k]) we_cnt++;
      if (sram_dq_oe[k]) oe_cnt++;
      if (lat == 1) begin
        chk("addr_lo", 32'(sram_addr[k]), base);
        chk("dq_lo", 32'(sram_dq_out[k]), w ? 32'(d[15:0]) : 32'd0);
      end
      if (lat == wc + 1) begin
        chk("addr_hi", 32'(sram_addr[k]), base + 32'd1);
        chk("dq_hi", 32'(sram_dq_out[k]), w ? 32'(d[31:16]) : 32'd0);
      end
    end
    chk("latency", 32'(lat), 32'(2 * wc + 1));
    chk("we_n_low_cycles", 32'(we_cnt), w ? 32'(2 * wc) : 32'd0);
    chk("oe_cycles", 32'(oe_cnt), w ? 32'(2 * wc) : 32'd0);
    chk("done_pins_idle", {29'd0, sram_we_n[k], sram_dq_oe[k], 1'b0}, 32'd4);
    rd = read_data[k];
  endtask

  task automatic go_idle(input int k);
    rd_en[k] = 1'b0; wr_en[k] = 1'b0;
    @(negedge clk);
    #1 chk("idle_ready", 32'(ready[k]), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rd_en[k] = 1'b0; wr_en[k] = 1'b0; address[k] = 32'd0; write_data[k] = 32'd0;
    end
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready[0]), 32'd1);
    chk("rst_we_n", 32'(sram_we_n[0]), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe[0]), 32'd0);
    chk("rst_rdata", read_data[0], 32'd0);
    chk("rst_addr", 32'(sram_addr[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    do_req(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'd0, rd_tmp);
    go_idle(0);
    chk("mem0", 32'(mem[0][0]), 32'h0000BEEF);
    chk("mem1", 32'(mem[0][1]), 32'h0000DEAD);
    do_req(0, 1'b1, 1'b0, 32'd1024, 32'd0, 32'd0, rd_tmp);
    chk("read_1024", rd_tmp, 32'hDEADBEEF);
    go_idle(0);
    do_req(0, 1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 32'd2, rd_tmp);
    go_idle(0);
    do_req(0, 1'b0, 1'b1, 32'd1032, 32'h12345678, 32'd4, rd_tmp);
    go_idle(0);
    chk("mem4", 32'(mem[0][4]), 32'h00005678);
    chk("mem5", 32'(mem[0][5]), 32'h00001234);
    do_req(0, 1'b1, 1'b0, 32'd1028, 32'd0, 32'd2, rd_tmp);
    chk("read_1028", rd_tmp, 32'hCAFEF00D);
    go_idle(0);
    do_req(0, 1'b1, 1'b1, 32'd1024, 32'h0000FFFF, 32'd0, rd_tmp);
    chk("both_rdata_kept", rd_tmp, 32'hCAFEF00D);
    go_idle(0);
    chk("both_mem0", 32'(mem[0][0]), 32'h0000FFFF);
    chk("both_mem1", 32'(mem[0][1]), 32'h00000000);
    @(negedge clk);
    wr_en[0] = 1'b1; address[0] = 32'd1036; write_data[0] = 32'h11112222;
    repeat (2) @(negedge clk);
    chk("pre_rst_we_n", 32'(sram_we_n[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_we_n", 32'(sram_we_n[0]), 32'd1);
    chk("mid_rst_oe", 32'(sram_dq_oe[0]), 32'd0);
    chk("mid_rst_rdata", read_data[0], 32'd0);
    chk("mid_rst_addr", 32'(sram_addr[0]), 32'd0);
    chk("mid_rst_ready_follows_req", 32'(ready[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    go_idle(0);
    do_req(0, 1'b1, 1'b0, 32'd1024, 32'd0, 32'd0, rd_tmp);
    chk("post_rst_read", rd_tmp, 32'h0000FFFF);
    go_idle(0);
    do_req(1, 1'b0, 1'b1, 32'd1024, 32'hA5A55A5A, 32'd0, rd_tmp);
    go_idle(1);
    do_req(1, 1'b0, 1'b1, 32'd1028, 32'h0BADC0DE, 32'd2, rd_tmp);
    go_idle(1);
    do_req(1, 1'b1, 1'b0, 32'd1024, 32'd0, 32'd0, rd_tmp);
    chk("w1_read_1024", rd_tmp, 32'hA5A55A5A);
    do_req(1, 1'b1, 1'b0, 32'd1028, 32'd0, 32'd2, rd_tmp);
    chk("w1_read_1028", rd_tmp, 32'h0BADC0DE);
    go_idle(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
